utim64_irq_ctrl: RTL and testbench
==================================

# utim64_irq_ctrl

Interrupt front-end for the 64-bit user timer. It consumes the four comparator interrupt lines and turns them into one prioritised request with a held vector. The CPU side acknowledges each request with a valid/ack handshake. Edge capture, a pending latch, an enable mask and per-channel missed-event counters are exposed through a small register port, so software can see interrupts that were dropped while a request was still outstanding.

## Interface
Parameters:
- P_CH, 4, number of interrupt channels (fixed at 4; vector is 2 bits)
- P_MISS_W, 8, width of each missed-event counter

Ports (one clock; reset is synchronous and active-high):
- iCLOCK  in  1  timer-domain clock, same clock that drives the comparators
- iRESET_SYNC  in  1  synchronous active-high reset
- iTIM_IRQ  in  4  comparator IRQ lines (bit n = comparator n), treated as level; rising edge = event
- iCFG_VALID  in  1  register access strobe, one cycle per access
- iCFG_RW  in  1  1 = write, 0 = read
- iCFG_ADDR  in  2  register select
- iCFG_DATA  in  32  write data
- oCFG_VALID  out  1  read data valid, one cycle
- oCFG_DATA  out  32  read data
- oIRQ_VALID  out  1  interrupt request to CPU
- oIRQ_NUM  out  2  vector of the presented channel, stable while oIRQ_VALID=1
- iIRQ_ACK  in  1  CPU acknowledge, sampled only while oIRQ_VALID=1

## Operation
- Edge detect: prev register. Event on channel n = iTIM_IRQ[n] & ~prev[n]. During reset, prev loads iTIM_IRQ, so a line that is high at reset release is not an event.
- Pending set rule:
  - An event sets pending[n] regardless of the enable bit.
  - An event on a channel whose pending bit is already 1 increments miss[n] instead, saturating at 255.
- Registers:
  - Addr 0 IER: bits[3:0] enable, reset 0, R/W. Bits [31:4] read 0.
  - Addr 1 PEND: bits[3:0], read. A write clears the bits where data=1 (W1C).
  - Addr 2 MISS: {miss3,miss2,miss1,miss0}, 8 bits each, read-to-clear. Writes are ignored.
  - Addr 3 STAT: bit0 = FSM in REQ, bits[2:1] = oIRQ_NUM, rest 0. Read-only.
- Priority: lowest channel index wins among (pending & IER).
- FSM states:
  - IDLE: if (pending & IER) != 0, latch the winning index into oIRQ_NUM and go to REQ.
  - REQ: oIRQ_VALID=1. oIRQ_NUM is held even if a higher-priority channel becomes pending. On iIRQ_ACK, clear pending[oIRQ_NUM] and go to IDLE.
  - REQ is never withdrawn. A W1C or IER clear of the presented channel does not drop oIRQ_VALID, and the ack still completes normally.
- Simultaneous events, same cycle:
  - Ack-clear and a new event on the same channel: set wins, pending stays 1, miss is unchanged.
  - W1C and a new event on the same channel: set wins.
  - MISS read-clear and an increment on the same channel: the counter becomes 1, and the read returns the pre-increment value.
- Reset mid-operation: all state returns to reset values in the next cycle, and any outstanding request is dropped without an ack.

## Timing
- Reset values:
  - oIRQ_VALID=0, oIRQ_NUM=0, oCFG_VALID=0, oCFG_DATA=0.
  - IER, PEND and MISS are 0. FSM is in IDLE.
- Event path latency:
  - iTIM_IRQ rises before edge k. Pending is set after edge k and is visible in PEND on a read issued in cycle k+1.
  - oIRQ_VALID asserts after edge k+1 (2 cycles from the input rise), provided the channel is enabled and the FSM is in IDLE.
- Ack: iIRQ_ACK high at edge j with oIRQ_VALID=1 gives oIRQ_VALID=0 after j.
  - The FSM spends at least one cycle in IDLE.
  - The next request is earliest at j+2 (the cycle that starts with edge j+2).
- iIRQ_ACK while oIRQ_VALID=0 is ignored.
- Register reads: oCFG_VALID and oCFG_DATA are registered, one cycle after iCFG_VALID. Back-to-back accesses every cycle are allowed.
- Register writes take effect after the same edge. An IER write enabling a pending channel can raise oIRQ_VALID one cycle later.

## Test plan
- Reset, then IER=4'hF and pulse iTIM_IRQ[2] at cycle 10 -> oIRQ_VALID=1, oIRQ_NUM=2 at cycle 12. Ack at 14 -> oIRQ_VALID=0 at 15 and PEND reads 0.
- Raise iTIM_IRQ[3] and iTIM_IRQ[1] in the same cycle -> vector 1 first. After its ack, vector 3 is presented 2 cycles later.
- Keep channel 0 pending and unacked, then apply 300 events on iTIM_IRQ[0] -> MISS reads 0x000000FF. A second MISS read returns 0.
- With IER=0, an event on ch2 -> no request and PEND=4'b0100. Then write IER=4'b0100 -> oIRQ_VALID a cycle later with vector 2.
- Ack of ch1 in the same cycle as a new ch1 edge -> PEND[1] stays 1, miss1 stays 0, and ch1 is re-requested 2 cycles later.
- Hold iTIM_IRQ[0]=1 across reset release -> no event, PEND=0. Assert reset while in REQ -> oIRQ_VALID=0 the next cycle and all registers read 0.

Source files
------------

// File: rtl/utim64_irq_ctrl.sv
// Interrupt front-end for the 64-bit user timer: edge capture, pending latch,
// enable mask, saturating missed-event counters and a held-vector request FSM.
module utim64_irq_ctrl #(
    parameter int P_CH     = 4,
    parameter int P_MISS_W = 8
) (
    input  logic              iCLOCK,
    input  logic              iRESET_SYNC,
    input  logic [P_CH-1:0]   iTIM_IRQ,
    input  logic              iCFG_VALID,
    input  logic              iCFG_RW,
    input  logic [1:0]        iCFG_ADDR,
    input  logic [31:0]       iCFG_DATA,
    output logic              oCFG_VALID,
    output logic [31:0]       oCFG_DATA,
    output logic              oIRQ_VALID,
    output logic [1:0]        oIRQ_NUM,
    input  logic              iIRQ_ACK
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [P_MISS_W-1:0] MISS_ONE = P_MISS_W'(1);

    state_t                     state_reg, state_next;
    logic [1:0]                 num_reg, num_next;
    logic                       holdoff_reg, holdoff_next;

    logic [P_CH-1:0]            prev_reg;
    logic [P_CH-1:0]            pend_reg, pend_next;
    logic [P_CH-1:0]            ier_reg, ier_next;
    logic [P_CH-1:0][P_MISS_W-1:0] miss_reg, miss_next;

    logic                       cfg_valid_reg;
    logic [31:0]                cfg_data_reg;
    logic [31:0]                rd_data;
    logic [31:0]                miss_word;

    logic [P_CH-1:0]            evt;
    logic [P_CH-1:0]            ack_clr;
    logic [P_CH-1:0]            w1c_clr;
    logic [P_CH-1:0]            miss_inc;
    logic [P_CH-1:0]            pend_en;

    logic                       cfg_rd;
    logic                       ier_wr;
    logic                       pend_wr;
    logic                       miss_rd;
    logic                       ack_fire;
    logic                       win_any;
    logic [1:0]                 win_idx;
    logic                       cfg_data_unused;

    assign cfg_rd   = iCFG_VALID & ~iCFG_RW;
    assign ier_wr   = iCFG_VALID &  iCFG_RW & (iCFG_ADDR == 2'd0);
    assign pend_wr  = iCFG_VALID &  iCFG_RW & (iCFG_ADDR == 2'd1);
    assign miss_rd  = cfg_rd & (iCFG_ADDR == 2'd2);
    assign ack_fire = (state_reg == ST_REQ) & iIRQ_ACK;
    assign pend_en  = pend_reg & ier_reg;

    assign cfg_data_unused = ^iCFG_DATA[31:P_CH];

    // A new edge always wins over ack-clear and W1C; it only counts as a miss
    // when the pending bit is already set and is not being cleared this cycle.
    generate
        for (genvar gi = 0; gi < P_CH; gi++) begin : g_ch
            assign evt[gi]       = iTIM_IRQ[gi] & ~prev_reg[gi];
            assign ack_clr[gi]   = ack_fire & (num_reg == 2'(gi));
            assign w1c_clr[gi]   = pend_wr & iCFG_DATA[gi];
            assign pend_next[gi] = evt[gi] | (pend_reg[gi] & ~(ack_clr[gi] | w1c_clr[gi]));
            assign miss_inc[gi]  = evt[gi] & pend_reg[gi] & ~ack_clr[gi] & ~w1c_clr[gi];

            always_comb begin
                miss_next[gi] = miss_reg[gi];
                if (miss_rd) begin
                    miss_next[gi] = miss_inc[gi] ? MISS_ONE : '0;
                end else if (miss_inc[gi] && (miss_reg[gi] != '1)) begin
                    miss_next[gi] = miss_reg[gi] + MISS_ONE;
                end
            end

            assign miss_word[gi*8 +: 8] = 8'(miss_reg[gi]);
        end
    endgenerate

    assign ier_next = ier_wr ? iCFG_DATA[P_CH-1:0] : ier_reg;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win_any = 1'b0;
        win_idx = 2'd0;
        for (int i = P_CH - 1; i >= 0; i--) begin
            if (pend_en[i]) begin
                win_any = 1'b1;
                win_idx = 2'(i);
            end
        end
    end

    // After an ack, holdoff keeps IDLE for one extra cycle so the next
    // request appears no earlier than two edges after the ack.
    always_comb begin
        state_next   = state_reg;
        num_next     = num_reg;
        holdoff_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (win_any && !holdoff_reg) begin
                    state_next = ST_REQ;
                    num_next   = win_idx;
                end
            end
            ST_REQ: begin
                if (iIRQ_ACK) begin
                    state_next   = ST_IDLE;
                    holdoff_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_data = 32'd0;
        case (iCFG_ADDR)
            2'd0:    rd_data = 32'(ier_reg);
            2'd1:    rd_data = 32'(pend_reg);
            2'd2:    rd_data = miss_word;
            default: rd_data = 32'({num_reg, (state_reg == ST_REQ)});
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        // prev follows the lines even in reset so a line high at release is not an edge
        prev_reg <= iTIM_IRQ;
        if (iRESET_SYNC) begin
            state_reg     <= ST_IDLE;
            num_reg       <= 2'd0;
            holdoff_reg   <= 1'b0;
            pend_reg      <= '0;
            ier_reg       <= '0;
            miss_reg      <= '0;
            cfg_valid_reg <= 1'b0;
            cfg_data_reg  <= 32'd0;
        end else begin
            state_reg     <= state_next;
            num_reg       <= num_next;
            holdoff_reg   <= holdoff_next;
            pend_reg      <= pend_next;
            ier_reg       <= ier_next;
            miss_reg      <= miss_next;
            cfg_valid_reg <= cfg_rd;
            if (cfg_rd) begin
                cfg_data_reg <= rd_data;
            end
        end
    end

    assign oIRQ_VALID = (state_reg == ST_REQ);
    assign oIRQ_NUM   = num_reg;
    assign oCFG_VALID = cfg_valid_reg;
    assign oCFG_DATA  = cfg_data_reg;

endmodule

// File: tb/tb_utim64_irq_ctrl.sv
// Bench for utim64_irq_ctrl: register table, event table and hand sequences,
// with a scoreboard queue for register read data.
module tb_utim64_irq_ctrl;

    logic        clk;
    logic        srst;
    logic [3:0]  tim_irq;
    logic        cfg_valid;
    logic        cfg_rw;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_rvalid;
    logic [31:0] cfg_rdata;
    logic        irq_valid;
    logic [1:0]  irq_num;
    logic        irq_ack;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    typedef struct {
        logic        rw;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [3:0]  pat;
        logic [31:0] exp_pend;
    } evt_vec_t;

    reg_vec_t rv [10];
    evt_vec_t ev [4];

    utim64_irq_ctrl #(.P_CH(4), .P_MISS_W(8)) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (srst),
        .iTIM_IRQ    (tim_irq),
        .iCFG_VALID  (cfg_valid),
        .iCFG_RW     (cfg_rw),
        .iCFG_ADDR   (cfg_addr),
        .iCFG_DATA   (cfg_data),
        .oCFG_VALID  (cfg_rvalid),
        .oCFG_DATA   (cfg_rdata),
        .oIRQ_VALID  (irq_valid),
        .oIRQ_NUM    (irq_num),
        .iIRQ_ACK    (irq_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_valid = 1'b1;
        cfg_rw    = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        step();
        cfg_valid = 1'b0;
        cfg_rw    = 1'b0;
        $display("wr addr=%0d data=%h", addr, data);
    endtask

    task automatic cfg_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        sb_entry_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        cfg_valid = 1'b1;
        cfg_rw    = 1'b0;
        cfg_addr  = addr;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] pat);
        tim_irq = pat;
        step();
        tim_irq = 4'b0000;
        step();
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic check_irq(input string name, input logic v, input logic [1:0] n);
        check({name, "_valid"}, 32'(irq_valid), 32'(v));
        if (v) check({name, "_num"}, 32'(irq_num), 32'(n));
    endtask

    always @(negedge clk) begin
        if (cfg_rvalid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_read: got valid data=%h want no read", cfg_rdata);
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                check(e.name, cfg_rdata, e.exp);
                $display("rd %s data=%h exp=%h", e.name, cfg_rdata, e.exp);
            end
        end
    end

    initial begin
        rv[0] = '{1'b0, 2'd0, 32'h0,        32'h0};
        rv[1] = '{1'b1, 2'd0, 32'hFFFF_FFF5, 32'h0};
        rv[2] = '{1'b0, 2'd0, 32'h0,        32'h5};
        rv[3] = '{1'b0, 2'd3, 32'h0,        32'h0};
        rv[4] = '{1'b0, 2'd2, 32'h0,        32'h0};
        rv[5] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
        rv[6] = '{1'b0, 2'd2, 32'h0,        32'h0};
        rv[7] = '{1'b1, 2'd0, 32'h0,        32'h0};
        rv[8] = '{1'b0, 2'd0, 32'h0,        32'h0};
        rv[9] = '{1'b0, 2'd1, 32'h0,        32'h0};

        ev[0] = '{4'b0001, 32'h1};
        ev[1] = '{4'b0110, 32'h6};
        ev[2] = '{4'b1010, 32'hA};
        ev[3] = '{4'b1111, 32'hF};

        srst      = 1'b1;
        tim_irq   = 4'b0001;
        cfg_valid = 1'b0;
        cfg_rw    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_data  = 32'd0;
        irq_ack   = 1'b0;
        repeat (3) step();
        srst = 1'b0;

        // reset values; ch0 is held high across release
        check_irq("rst", 1'b0, 2'd0);
        check("rst_irq_num", 32'(irq_num), 32'd0);
        check("rst_cfg_valid", 32'(cfg_rvalid), 32'd0);
        check("rst_cfg_data", cfg_rdata, 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (rv[i].rw) cfg_write(rv[i].addr, rv[i].data);
            else          cfg_read(rv[i].addr, rv[i].exp, $sformatf("regvec%0d", i));
        end
        tim_irq = 4'b0000;
        step();
        check_irq("held_release", 1'b0, 2'd0);

        // IER=0: events latch without requests, then W1C clears them
        for (int i = 0; i < 4; i++) begin
            pulse(ev[i].pat);
            check_irq($sformatf("evvec%0d_noreq", i), 1'b0, 2'd0);
            cfg_read(2'd1, ev[i].exp_pend, $sformatf("evvec%0d_pend", i));
            cfg_write(2'd1, 32'hF);
            cfg_read(2'd1, 32'h0, $sformatf("evvec%0d_w1c", i));
        end

        // basic request latency and ack
        cfg_write(2'd0, 32'hF);
        tim_irq = 4'b0100;
        step();
        check_irq("lat_k", 1'b0, 2'd0);
        tim_irq = 4'b0000;
        step();
        check_irq("lat_k1", 1'b1, 2'd2);
        cfg_read(2'd3, 32'h5, "stat_req2");
        ack();
        check_irq("ack_drop", 1'b0, 2'd0);
        cfg_read(2'd1, 32'h0, "pend_after_ack");

        // simultaneous ch3+ch1: ch1 first, ch3 two cycles after the ack
        pulse(4'b1010);
        check_irq("prio_first", 1'b1, 2'd1);
        ack();
        check_irq("prio_j", 1'b0, 2'd0);
        step();
        check_irq("prio_j1", 1'b0, 2'd0);
        step();
        check_irq("prio_j2", 1'b1, 2'd3);
        ack();
        cfg_read(2'd1, 32'h0, "prio_pend");

        // vector held against higher priority and survives W1C of itself
        pulse(4'b0100);
        check_irq("hold_req", 1'b1, 2'd2);
        pulse(4'b0001);
        check_irq("hold_hi", 1'b1, 2'd2);
        cfg_write(2'd1, 32'h4);
        check_irq("hold_w1c", 1'b1, 2'd2);
        cfg_read(2'd1, 32'h1, "hold_pend");
        ack();
        step();
        step();
        check_irq("hold_next", 1'b1, 2'd0);
        ack();
        cfg_read(2'd1, 32'h0, "hold_pend_clr");

        // miss saturation and read-clear racing an increment
        pulse(4'b0001);
        check_irq("miss_req", 1'b1, 2'd0);
        for (int i = 0; i < 300; i++) pulse(4'b0001);
        check_irq("miss_still", 1'b1, 2'd0);
        cfg_read(2'd2, 32'h0000_00FF, "miss_sat");
        cfg_read(2'd2, 32'h0, "miss_clr");
        pulse(4'b0001);
        tim_irq = 4'b0001;
        cfg_read(2'd2, 32'h1, "miss_race_pre");
        tim_irq = 4'b0000;
        cfg_read(2'd2, 32'h1, "miss_race_post");
        ack();
        cfg_read(2'd1, 32'h0, "miss_pend");

        // masked event, stray ack ignored, IER enable, IER clear keeps request
        cfg_write(2'd0, 32'h0);
        pulse(4'b0100);
        check_irq("mask_noreq", 1'b0, 2'd0);
        ack();
        cfg_read(2'd1, 32'h4, "mask_pend");
        cfg_write(2'd0, 32'h4);
        check_irq("ier_e", 1'b0, 2'd0);
        step();
        check_irq("ier_e1", 1'b1, 2'd2);
        cfg_write(2'd0, 32'h0);
        check_irq("ier_clr_hold", 1'b1, 2'd2);
        ack();
        check_irq("ier_ack", 1'b0, 2'd0);
        cfg_read(2'd1, 32'h0, "ier_pend");
        cfg_write(2'd0, 32'hF);

        // ack and new edge on ch1 in the same cycle
        pulse(4'b0010);
        check_irq("race_req", 1'b1, 2'd1);
        irq_ack = 1'b1;
        tim_irq = 4'b0010;
        step();
        irq_ack = 1'b0;
        tim_irq = 4'b0000;
        check_irq("race_j", 1'b0, 2'd0);
        step();
        check_irq("race_j1", 1'b0, 2'd0);
        step();
        check_irq("race_j2", 1'b1, 2'd1);
        cfg_read(2'd1, 32'h2, "race_pend");
        cfg_read(2'd2, 32'h0, "race_miss");
        ack();
        cfg_read(2'd1, 32'h0, "race_pend_clr");

        // reset while a request is outstanding
        pulse(4'b0100);
        pulse(4'b0100);
        check_irq("mid_req", 1'b1, 2'd2);
        srst = 1'b1;
        step();
        check_irq("mid_rst", 1'b0, 2'd0);
        check("mid_rst_num", 32'(irq_num), 32'd0);
        srst = 1'b0;
        cfg_read(2'd0, 32'h0, "mid_ier");
        cfg_read(2'd1, 32'h0, "mid_pend");
        cfg_read(2'd2, 32'h0, "mid_miss");
        cfg_read(2'd3, 32'h0, "mid_stat");
        step();
        step();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
